// File: rtl/reg_status_file_pkg.sv
// Shared rename-status constants, also used by the decoder and the ROB.
package reg_status_file_pkg;
  localparam int NREG_DEF  = 32;
  localparam int REG_IDX_W = $clog2(NREG_DEF);
  localparam int TAG_W_DEF = 4;
  localparam int XLEN_DEF  = 32;
  // A free register reports this tag on its read port.
  localparam logic [TAG_W_DEF-1:0] TAG_EMPTY = '0;
endpackage

// File: rtl/reg_status_file_if.sv
// Decode/ROB-facing bundle of the rename status file: read, rename and commit ports.
interface reg_status_file_if import reg_status_file_pkg::*; #(
  parameter int NREG  = NREG_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NRD   = 2,
  parameter int NCMT  = 1
);
  localparam int IW = $clog2(NREG);

  logic                            rdy;
  logic                            flush;
  logic [NRD-1:0][IW-1:0]          rd_idx;
  logic [NRD-1:0]                  rd_busy;
  logic [NRD-1:0][TAG_W-1:0]       rd_tag;
  logic [NRD-1:0][XLEN-1:0]        rd_val;
  logic                            ren_valid;
  logic [IW-1:0]                   ren_idx;
  logic [TAG_W-1:0]                ren_tag;
  logic [NCMT-1:0]                 cmt_valid;
  logic [NCMT-1:0][IW-1:0]         cmt_idx;
  logic [NCMT-1:0][TAG_W-1:0]      cmt_tag;
  logic [NCMT-1:0][XLEN-1:0]       cmt_val;
  logic [IW:0]                     busy_cnt;

  modport master (
    output rdy, flush, rd_idx, ren_valid, ren_idx, ren_tag,
           cmt_valid, cmt_idx, cmt_tag, cmt_val,
    input  rd_busy, rd_tag, rd_val, busy_cnt
  );
  modport slave (
    input  rdy, flush, rd_idx, ren_valid, ren_idx, ren_tag,
           cmt_valid, cmt_idx, cmt_tag, cmt_val,
    output rd_busy, rd_tag, rd_val, busy_cnt
  );
endinterface

// File: rtl/reg_status_bypass.sv
// Per-read-port commit bypass; REG_STATUS_BYPASS_EN enables it, otherwise a pass-through.
module reg_status_bypass #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int NCMT  = 1
) (
  input  logic                       busy_i,
  input  logic [TAG_W-1:0]           tag_i,
  input  logic [XLEN-1:0]            val_i,
  input  logic [NCMT-1:0]            cmt_valid_i,
  input  logic [NCMT-1:0][TAG_W-1:0] cmt_tag_i,
  input  logic [NCMT-1:0][XLEN-1:0]  cmt_val_i,
  output logic                       busy_o,
  output logic [TAG_W-1:0]           tag_o,
  output logic [XLEN-1:0]            val_o
);
`ifdef REG_STATUS_BYPASS_EN
  always_comb begin
    busy_o = busy_i;
    val_o  = val_i;
    for (int c = 0; c < NCMT; c++) begin
      if (busy_i && cmt_valid_i[c] && cmt_tag_i[c] == tag_i) begin
        busy_o = 1'b0;
        val_o  = cmt_val_i[c];
      end
    end
  end
`else
  logic unused_cmt;
  assign unused_cmt = ^{cmt_valid_i, cmt_tag_i, cmt_val_i};
  assign busy_o = busy_i;
  assign val_o  = val_i;
`endif
  assign tag_o = busy_o ? tag_i : '0;
endmodule

// File: rtl/reg_status_file.sv
// Architectural register values plus rename busy/tag per register, incremental busy count.
// Optional same-cycle commit bypass on the read ports: define REG_STATUS_BYPASS_EN.
module reg_status_file import reg_status_file_pkg::*; #(
  parameter int NREG  = NREG_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NRD   = 2,
  parameter int NCMT  = 1
) (
  input logic               clk,
  input logic               rst_n,
  reg_status_file_if.slave  bus
);
  localparam int IW = $clog2(NREG);

  logic [NREG-1:0][XLEN-1:0]  val_q, val_d;
  logic [NREG-1:0]            busy_q, busy_d;
  logic [NREG-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [IW:0]                cnt_q, cnt_d, n_clr;
  logic [NCMT-1:0]            eff_clr;
  logic                       ren_ok, ren_inc;

  always_comb begin
    val_d   = val_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    eff_clr = '0;
    n_clr   = '0;
    ren_ok  = bus.ren_valid && !bus.flush && bus.ren_idx != '0;
    ren_inc = ren_ok && !busy_q[bus.ren_idx];
    for (int c = 0; c < NCMT; c++) begin
      if (bus.cmt_valid[c] && bus.cmt_idx[c] != '0) begin
        val_d[bus.cmt_idx[c]] = bus.cmt_val[c];
        // A same-cycle rename keeps the register busy, so the clear does not count.
        eff_clr[c] = busy_q[bus.cmt_idx[c]] && tag_q[bus.cmt_idx[c]] == bus.cmt_tag[c] &&
                     !(ren_ok && bus.ren_idx == bus.cmt_idx[c]);
        for (int k = 0; k < c; k++)
          if (eff_clr[k] && bus.cmt_idx[k] == bus.cmt_idx[c]) eff_clr[c] = 1'b0;
        if (eff_clr[c]) begin
          busy_d[bus.cmt_idx[c]] = 1'b0;
          n_clr = n_clr + 1'b1;
        end
      end
    end
    if (bus.flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (ren_ok) begin
        busy_d[bus.ren_idx] = 1'b1;
        tag_d[bus.ren_idx]  = bus.ren_tag;
      end
      cnt_d = cnt_q - n_clr + {{IW{1'b0}}, ren_inc};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
      cnt_q  <= '0;
    end else if (bus.rdy) begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.busy_cnt = cnt_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [IW-1:0]    ix;
    logic             busy_w;
    logic [TAG_W-1:0] tag_w;
    logic [XLEN-1:0]  val_w;
    assign ix = bus.rd_idx[p];
    reg_status_bypass #(.XLEN(XLEN), .TAG_W(TAG_W), .NCMT(NCMT)) u_byp (
      .busy_i      (busy_q[ix]),
      .tag_i       (tag_q[ix]),
      .val_i       (val_q[ix]),
      .cmt_valid_i (bus.cmt_valid),
      .cmt_tag_i   (bus.cmt_tag),
      .cmt_val_i   (bus.cmt_val),
      .busy_o      (busy_w),
      .tag_o       (tag_w),
      .val_o       (val_w)
    );
    assign bus.rd_busy[p] = busy_w;
    assign bus.rd_tag[p]  = tag_w;
    assign bus.rd_val[p]  = val_w;
  end
endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: rule-level model checked every cycle plus literal pins.
module tb_reg_status_file;
  localparam int NREG = 32, XLEN = 32, TAG_W = 4, NRD = 2, NCMT = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_status_file_if #(.NREG(NREG), .XLEN(XLEN), .TAG_W(TAG_W), .NRD(NRD), .NCMT(NCMT)) bus ();
  reg_status_file #(.NREG(NREG), .XLEN(XLEN), .TAG_W(TAG_W), .NRD(NRD), .NCMT(NCMT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: plain arrays following the register rules directly.
  logic [XLEN-1:0]  m_val  [NREG];
  logic             m_busy [NREG];
  logic [TAG_W-1:0] m_tag  [NREG];

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    bit hit [NREG];
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0; end
    end else if (bus.rdy) begin
      for (int i = 0; i < NREG; i++) hit[i] = 1'b0;
      for (int c = 0; c < NCMT; c++)
        if (bus.cmt_valid[c] && bus.cmt_idx[c] != 0) begin
          if (m_busy[bus.cmt_idx[c]] && m_tag[bus.cmt_idx[c]] == bus.cmt_tag[c]) hit[bus.cmt_idx[c]] = 1'b1;
          m_val[bus.cmt_idx[c]] = bus.cmt_val[c];
        end
      if (bus.flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      end else begin
        for (int i = 0; i < NREG; i++) if (hit[i]) m_busy[i] = 1'b0;
        if (bus.ren_valid && bus.ren_idx != 0) begin
          m_busy[bus.ren_idx] = 1'b1;
          m_tag[bus.ren_idx]  = bus.ren_tag;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NRD; p++) begin
        logic             eb;
        logic [XLEN-1:0]  ev;
        logic [TAG_W-1:0] et;
        eb = m_busy[bus.rd_idx[p]];
        ev = m_val[bus.rd_idx[p]];
        et = m_tag[bus.rd_idx[p]];
`ifdef REG_STATUS_BYPASS_EN
        for (int c = 0; c < NCMT; c++)
          if (eb && bus.cmt_valid[c] && bus.cmt_tag[c] == et) begin eb = 1'b0; ev = bus.cmt_val[c]; end
`endif
        if (!eb) et = '0;
        chk("cyc_busy", 64'(bus.rd_busy[p]), 64'(eb));
        chk("cyc_tag",  64'(bus.rd_tag[p]),  64'(et));
        chk("cyc_val",  64'(bus.rd_val[p]),  64'(ev));
      end
      chk("cyc_cnt", 64'(bus.busy_cnt), 64'(m_cnt()));
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic idle();
    bus.ren_valid = 1'b0; bus.cmt_valid = '0; bus.flush = 1'b0;
  endtask
  task automatic ren(input logic [4:0] i, input logic [3:0] t);
    bus.ren_valid = 1'b1; bus.ren_idx = i; bus.ren_tag = t;
  endtask
  task automatic cmt(input logic [4:0] i, input logic [3:0] t, input logic [31:0] v);
    bus.cmt_valid = 1'b1; bus.cmt_idx[0] = i; bus.cmt_tag[0] = t; bus.cmt_val[0] = v;
  endtask
  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    bus.rd_idx[0] = a; bus.rd_idx[1] = b; #1;
  endtask
  task automatic pin(input string nm, input logic b, input logic [3:0] t, input logic [31:0] v);
    chk({nm, "_busy"}, 64'(bus.rd_busy[0]), 64'(b));
    chk({nm, "_tag"},  64'(bus.rd_tag[0]),  64'(t));
    chk({nm, "_val"},  64'(bus.rd_val[0]),  64'(v));
  endtask

  initial begin
    bus.rdy = 1'b1; idle();
    bus.ren_idx = '0; bus.ren_tag = '0;
    bus.cmt_idx = '0; bus.cmt_tag = '0; bus.cmt_val = '0;
    bus.rd_idx = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    #18 rd(5'd5, 5'd0);
    pin("rst_x5", 1'b0, 4'd0, 32'h0);
    chk("rst_cnt", 64'(bus.busy_cnt), 64'd0);
    #1 rst_n = 1'b1;

    ren(5'd5, 4'd3); tick(); idle(); rd(5'd5, 5'd0);
    pin("ren_x5", 1'b1, 4'd3, 32'h0);
    chk("ren_cnt", 64'(bus.busy_cnt), 64'd1);

    cmt(5'd5, 4'd3, 32'hDEADBEEF);
`ifdef REG_STATUS_BYPASS_EN
    #1 pin("byp_x5", 1'b0, 4'd0, 32'hDEADBEEF);
`endif
    tick(); idle(); rd(5'd5, 5'd0);
    pin("cmt_x5", 1'b0, 4'd0, 32'hDEADBEEF);
    chk("cmt_cnt", 64'(bus.busy_cnt), 64'd0);

    ren(5'd7, 4'd2); tick();
    ren(5'd7, 4'd6); tick(); idle();
    chk("reren_cnt", 64'(bus.busy_cnt), 64'd1);
    cmt(5'd7, 4'd2, 32'h11); tick(); idle(); rd(5'd7, 5'd5);
    pin("stale_x7", 1'b1, 4'd6, 32'h11);
    chk("stale_cnt", 64'(bus.busy_cnt), 64'd1);

    ren(5'd9, 4'd1); tick();
    ren(5'd9, 4'd4); cmt(5'd9, 4'd4, 32'h22); tick(); idle(); rd(5'd9, 5'd7);
    pin("same_x9", 1'b1, 4'd4, 32'h22);
    chk("same_cnt", 64'(bus.busy_cnt), 64'd2);

    ren(5'd1, 4'd8); tick();
    ren(5'd2, 4'd9); tick();
    ren(5'd3, 4'd10); tick(); idle();
    chk("pre_flush_cnt", 64'(bus.busy_cnt), 64'd5);
    bus.flush = 1'b1; ren(5'd4, 4'd11); cmt(5'd1, 4'd8, 32'h33);
    tick(); idle(); rd(5'd1, 5'd4);
    pin("flush_x1", 1'b0, 4'd0, 32'h33);
    chk("flush_x4_busy", 64'(bus.rd_busy[1]), 64'd0);
    chk("flush_cnt", 64'(bus.busy_cnt), 64'd0);
    rd(5'd9, 5'd2);
    pin("flush_x9", 1'b0, 4'd0, 32'h22);

    ren(5'd0, 4'd5); cmt(5'd0, 4'd5, 32'h55); tick(); idle(); rd(5'd0, 5'd9);
    pin("x0", 1'b0, 4'd0, 32'h0);
    chk("x0_cnt", 64'(bus.busy_cnt), 64'd0);

    bus.rdy = 1'b0; ren(5'd5, 4'd12); cmt(5'd5, 4'd3, 32'h44);
    tick(); tick(); idle(); bus.rdy = 1'b1; rd(5'd5, 5'd0);
    pin("rdy_x5", 1'b0, 4'd0, 32'hDEADBEEF);
    chk("rdy_cnt", 64'(bus.busy_cnt), 64'd0);

    ren(5'd6, 4'd7); tick(); idle(); rd(5'd6, 5'd0);
    pin("pre_rst_x6", 1'b1, 4'd7, 32'h0);
    ren(5'd8, 4'd13); cmt(5'd5, 4'd1, 32'h66);
    #1 rst_n = 1'b0;
    #1 rd(5'd6, 5'd5);
    pin("arst_x6", 1'b0, 4'd0, 32'h0);
    chk("arst_x5_val", 64'(bus.rd_val[1]), 64'd0);
    chk("arst_cnt", 64'(bus.busy_cnt), 64'd0);
    tick(); idle(); #1 rst_n = 1'b1;
    tick(); rd(5'd8, 5'd5);
    pin("post_rst_x8", 1'b0, 4'd0, 32'h0);
    chk("post_rst_cnt", 64'(bus.busy_cnt), 64'd0);

    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_status_file.md
# reg_status_file

Parametrised architectural register file with per-register rename status for the out-of-order core. It sits between the decoder and the ROB/RS dispatch path. Decode reads source operands as either a ready value or a pending ROB tag, and renames destinations at dispatch. The ROB writes committed results back and clears tags only when they still match. It generalises the current decode-local register/tag arrays to N read ports, up to two commit ports, a flush path, a live busy counter and optional same-cycle commit bypass.

## Interface
- NREG, 32, number of architectural registers; index 0 is hard-wired zero
- XLEN, 32, data width
- TAG_W, 4, ROB tag width
- NRD, 2, number of source read ports
- NCMT, 1, number of commit ports (1 or 2)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global ready; low freezes all state
- flush  in  1  misprediction clear from flow control
- rd_idx  in  NRD*$clog2(NREG)  source register indices, port p at slice p
- rd_busy  out  NRD  port p operand pending
- rd_tag  out  NRD*TAG_W  producing ROB tag, valid when busy
- rd_val  out  NRD*XLEN  operand value, valid when not busy
- ren_valid  in  1  rename destination this cycle
- ren_idx  in  $clog2(NREG)  destination register
- ren_tag  in  TAG_W  ROB tag allocated to the destination
- cmt_valid  in  NCMT  commit strobe per port
- cmt_idx  in  NCMT*$clog2(NREG)  committed register
- cmt_tag  in  NCMT*TAG_W  ROB tag of the committing entry
- cmt_val  in  NCMT*XLEN  committed value
- busy_cnt  out  $clog2(NREG)+1  number of registers currently busy

## Operation
- State per register: val[XLEN], busy bit, tag[TAG_W]. Register 0 reads val=0 and busy=0. Writes and renames to register 0 are dropped.
- Read ports are combinational from the current state (plus bypass, see Configuration). rd_tag is driven 0 when not busy.
- Rename (ren_valid, rdy, !flush, ren_idx≠0): busy←1, tag←ren_tag. Renaming an already-busy register overwrites the tag. busy_cnt is unchanged in that case.
- Commit, each port (cmt_valid, rdy, idx≠0): val←cmt_val unconditionally.
  - busy←0 only if busy && tag==cmt_tag.
  - A stale tag writes the value and leaves busy/tag untouched.
- Same-cycle rename and commit to the same register: the commit value is written and the rename wins for busy/tag, so the register stays busy with ren_tag.
- Two commit ports naming the same register: port NCMT-1 value wins; either matching tag clears busy.
- Flush (rdy high): all busy←0, busy_cnt←0, rename ignored; commits in the same cycle still write values.
- busy_cnt is maintained incrementally: +1 for a rename of a non-busy register, −1 per effective clear. It is never recomputed by popcount. It must equal popcount(busy) at every edge; the bench asserts this.

## Timing
- rst_n low, asynchronously: all val=0, busy=0, tag=0, busy_cnt=0. Outputs settle combinationally to rd_busy=0, rd_tag=0, rd_val=0. Reset mid-operation discards any pending rename or commit.
- All state updates on the rising clk edge with rdy high; rdy low holds every register, and inputs are ignored.
- Rename is visible on read ports in the cycle after ren_valid.
- Commit is visible in the following cycle, or the same cycle with bypass.
- No handshake: the producer guarantees ren_tag is unique among busy registers.

## Configuration
- REG_STATUS_BYPASS_EN defined: a read port whose register is busy, and whose tag matches a valid commit in the same cycle, returns busy=0 and rd_val=cmt_val combinationally.
  - A rename in the same cycle does not affect reads.
- Undefined: reads reflect registered state only; commit results appear one cycle later.

## Structure
- Shared package/constants header: REG_IDX_W, TAG_W, XLEN defaults, and the tag-empty encoding, reused by the decoder and ROB.
- One sub-module, reg_status_bypass: per-read-port bypass mux comparing rd tag against all commit ports. It is instantiated NRD times and reduces to a pass-through when the macro is off.

## Test plan
- Reset release, read x5 → busy=0, val=0, busy_cnt=0.
- Rename x5 tag 3; next cycle read x5 → busy=1, tag=3, busy_cnt=1.
- Commit x5 tag 3 val 0xDEADBEEF → next cycle busy=0, val=0xDEADBEEF, busy_cnt=0. With bypass, the same-cycle read already shows 0xDEADBEEF.
- Rename x7 tag 2, then rename x7 tag 6, then commit x7 tag 2 val 0x11 → val=0x11, still busy with tag 6, busy_cnt=1.
- Same cycle: rename x9 tag 4 and commit x9 tag 4 val 0x22 (prior tag 1) → val=0x22, busy=1, tag=4.
- Rename x1..x3, then flush with commit x1 tag of x1 val 0x33 → all busy=0, busy_cnt=0, x1=0x33. Rename x0 tag 5 → x0 stays busy=0, val=0. Drop rdy during a rename → no state change.
